irq_pad_ctrl: RTL and testbench

- Parametrised interrupt front-end between the pad ring and the SOC.
- Takes NUM_CH asynchronous IRQ lines from gpio_input pads.
  - Synchronises and glitch-filters each line.
  - Detects edge- or level-triggered events per channel.
  - Holds pending state and presents the lowest-index pending channel to the SOC.
- Converts SOC acknowledgements into timed EOI pulses driven to gpio_output pads.
- Successor to the fixed 16-in/16-out irq/eoi pad hookup.

---
 rtl/irq_pad_ctrl_if.sv | 27 ++
 rtl/irq_pad_ctrl.sv | 156 +++++++++++++++
 tb/tb_irq_pad_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_pad_ctrl_if.sv
// SOC-side interrupt/acknowledge bundle for irq_pad_ctrl.
// The controller drives the slave modport; the SOC (or a bench) drives the master modport.
interface irq_pad_ctrl_if #(
  parameter int NUM_CH = 16,
  parameter int IDW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  // Handshake: irq_valid/irq_id are levels that track irq_pending and need no
  // ready. ack_valid is a one-cycle strobe that is always consumed. A valid ack
  // (in range and pending) clears that channel next cycle. Any other ack
  // changes nothing and answers with a one-cycle ack_err pulse the cycle after.
  logic [NUM_CH-1:0] irq_pending;
  logic              irq_valid;
  logic [IDW-1:0]    irq_id;
  logic              ack_valid;
  logic [IDW-1:0]    ack_id;
  logic              ack_err;

  modport master (
    input  irq_pending, irq_valid, irq_id, ack_err,
    output ack_valid, ack_id
  );

  modport slave (
    output irq_pending, irq_valid, irq_id, ack_err,
    input  ack_valid, ack_id
  );
endinterface

// File: rtl/irq_pad_ctrl.sv
// Pad-ring interrupt front-end: sync, glitch filter, edge/level pending, priority present, timed EOI pulses.
// Optional macro IRQ_OVF_TRACK_EN adds the sticky per-channel irq_ovf output.
module irq_pad_ctrl #(
  parameter int NUM_CH      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int EOI_PULSE   = 8,
  parameter int IDW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  irq_pad_ctrl_if.slave     soc,
  input  logic [NUM_CH-1:0] irq_pad_in,
  input  logic [NUM_CH-1:0] cfg_en,
  input  logic [NUM_CH-1:0] cfg_edge,
  output logic [NUM_CH-1:0] eoi_pad_out
`ifdef IRQ_OVF_TRACK_EN
  ,
  output logic [NUM_CH-1:0] irq_ovf
`endif
);

  localparam int CW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam int EW = $clog2(EOI_PULSE + 1);
  localparam logic [CW-1:0] FILT_LAST = CW'(FILT_CYCLES - 1);
  localparam logic [EW-1:0] EOI_LOAD  = EW'(EOI_PULSE);

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] synced;
  logic [NUM_CH-1:0] filt_q;
  logic [NUM_CH-1:0] filt_d;
  logic [CW-1:0]     filt_cnt [NUM_CH];
  logic [EW-1:0]     eoi_cnt  [NUM_CH];
  logic [NUM_CH-1:0] eoi_busy;
  logic [NUM_CH-1:0] pending_q;
  logic [NUM_CH-1:0] pending_d;
  logic [NUM_CH-1:0] ack_hit;
  logic [NUM_CH-1:0] edge_set;
  logic [NUM_CH-1:0] level_set;
  logic [NUM_CH-1:0] set_ev;
  logic              ack_ok;
  logic              ack_err_q;
  logic [IDW-1:0]    id_sel;

  // ---------------------------------------------------------------- synchroniser
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= irq_pad_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------- glitch filter
  // The counter only runs while synced disagrees with the filtered value; the
  // FILT_CYCLES-th consecutive disagreement commits the new value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= '0;
      filt_d <= '0;
      for (int i = 0; i < NUM_CH; i++) filt_cnt[i] <= '0;
    end else begin
      filt_d <= filt_q;
      for (int i = 0; i < NUM_CH; i++) begin
        if (synced[i] != filt_q[i]) begin
          if (filt_cnt[i] == FILT_LAST) begin
            filt_q[i]   <= synced[i];
            filt_cnt[i] <= '0;
          end else begin
            filt_cnt[i] <= filt_cnt[i] + 1'b1;
          end
        end else begin
          filt_cnt[i] <= '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------- ack decode and events
  always_comb begin
    ack_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ack_hit[i] = soc.ack_valid && (soc.ack_id == IDW'(i)) && pending_q[i];
    end
  end

  assign ack_ok = |ack_hit;

  always_comb begin
    eoi_busy = '0;
    for (int i = 0; i < NUM_CH; i++) eoi_busy[i] = (eoi_cnt[i] != '0);
  end

  // A level channel being acked starts its EOI pulse this cycle. It is held off
  // like a channel already in its pulse, so the ack actually drops it.
  assign edge_set  = cfg_edge & filt_q & ~filt_d;
  assign level_set = ~cfg_edge & filt_q & ~eoi_busy & ~ack_hit;
  assign set_ev    = cfg_en & (edge_set | level_set);
  assign pending_d = set_ev | (pending_q & ~ack_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      ack_err_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      ack_err_q <= soc.ack_valid && !ack_ok;
    end
  end

  // ---------------------------------------------------------------- EOI pulse timers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) eoi_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ack_hit[i])       eoi_cnt[i] <= EOI_LOAD;
        else if (eoi_busy[i]) eoi_cnt[i] <= eoi_cnt[i] - 1'b1;
      end
    end
  end

  assign eoi_pad_out = eoi_busy;

  // ---------------------------------------------------------------- presentation
  always_comb begin
    id_sel = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending_q[i]) id_sel = IDW'(i);
    end
  end

  assign soc.irq_pending = pending_q;
  assign soc.irq_valid   = |pending_q;
  assign soc.irq_id      = id_sel;
  assign soc.ack_err     = ack_err_q;

`ifdef IRQ_OVF_TRACK_EN
  // ---------------------------------------------------------------- overflow tracking
  logic [NUM_CH-1:0] ovf_q;
  logic [NUM_CH-1:0] ovf_set;

  assign ovf_set = cfg_en & edge_set & pending_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= '0;
    else     ovf_q <= ovf_set | (ovf_q & ~ack_hit);
  end

  assign irq_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_irq_pad_ctrl.sv
// Directed bench for irq_pad_ctrl: a channel-level behavioural model checked every cycle
// plus hand-computed latency/pulse-width expectations and a small instance for out-of-range acks.
module tb_irq_pad_ctrl;
  localparam int N   = 16;
  localparam int SS  = 2;
  localparam int FC  = 4;
  localparam int EP  = 8;
  localparam int IDW = 4;
  localparam int SN  = 5;
  localparam int SIDW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] pad_v, en_v, edge_v, eoi_o;
  logic ack_v;
  logic [IDW-1:0] ack_i;
  logic [SN-1:0] sm_pad, sm_en, sm_edge, sm_eoi;
`ifdef IRQ_OVF_TRACK_EN
  logic [N-1:0] ovf_o;
  logic [SN-1:0] sm_ovf;
`endif

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  irq_pad_ctrl_if #(.NUM_CH(N), .IDW(IDW)) soc_if ();
  irq_pad_ctrl_if #(.NUM_CH(SN), .IDW(SIDW)) sm_if ();

  assign soc_if.ack_valid = ack_v;
  assign soc_if.ack_id    = ack_i;

  irq_pad_ctrl #(.NUM_CH(N), .SYNC_STAGES(SS), .FILT_CYCLES(FC), .EOI_PULSE(EP), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .soc(soc_if),
    .irq_pad_in(pad_v), .cfg_en(en_v), .cfg_edge(edge_v), .eoi_pad_out(eoi_o)
`ifdef IRQ_OVF_TRACK_EN
    , .irq_ovf(ovf_o)
`endif
  );

  irq_pad_ctrl #(.NUM_CH(SN), .SYNC_STAGES(SS), .FILT_CYCLES(FC), .EOI_PULSE(EP), .IDW(SIDW)) u_small (
    .clk(clk), .rst(rst), .soc(sm_if),
    .irq_pad_in(sm_pad), .cfg_en(sm_en), .cfg_edge(sm_edge), .eoi_pad_out(sm_eoi)
`ifdef IRQ_OVF_TRACK_EN
    , .irq_ovf(sm_ovf)
`endif
  );

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- behavioural model
  logic [N-1:0] m_pad_q[$];
  logic [N-1:0] m_synced, m_filt, m_fresh, m_pend, m_ovf;
  int m_run[N];
  int m_eoi[N];
  logic m_err;

  task automatic model_reset();
    m_pad_q = {};
    for (int s = 0; s < SS - 1; s++) m_pad_q.push_back('0);
    m_synced = '0; m_filt = '0; m_fresh = '0; m_pend = '0; m_ovf = '0; m_err = 1'b0;
    for (int i = 0; i < N; i++) begin m_run[i] = 0; m_eoi[i] = 0; end
  endtask

  // One clock edge of channel behaviour, evaluated from the pre-edge model state.
  task automatic model_step();
    logic [N-1:0] hit, set_v, ovf_v;
    hit = '0; set_v = '0; ovf_v = '0;
    for (int i = 0; i < N; i++) begin
      hit[i] = ack_v && (int'(ack_i) == i) && m_pend[i];
      if (en_v[i]) begin
        if (edge_v[i]) set_v[i] = m_fresh[i];
        else           set_v[i] = m_filt[i] && (m_eoi[i] == 0) && !hit[i];
      end
      ovf_v[i] = set_v[i] && edge_v[i] && m_pend[i];
    end
    m_err = ack_v && (hit == '0);
    for (int i = 0; i < N; i++) begin
      m_pend[i] = set_v[i] || (m_pend[i] && !hit[i]);
      m_ovf[i]  = ovf_v[i] || (m_ovf[i] && !hit[i]);
      if (hit[i])          m_eoi[i] = EP;
      else if (m_eoi[i] > 0) m_eoi[i] = m_eoi[i] - 1;
      m_fresh[i] = 1'b0;
      if (m_synced[i] != m_filt[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == FC) begin
          m_filt[i] = m_synced[i]; m_fresh[i] = m_synced[i]; m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_pad_q.push_back(pad_v);
    m_synced = m_pad_q.pop_front();
  endtask

  function automatic logic [IDW-1:0] low_id(logic [N-1:0] p);
    for (int i = 0; i < N; i++) if (p[i]) return IDW'(i);
    return '0;
  endfunction

  function automatic logic [N-1:0] eoi_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (m_eoi[i] > 0);
    return v;
  endfunction

  // ---------------------------------------------------------------- scoreboard
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && cmp_on) begin
      check("m_pending", soc_if.irq_pending, m_pend);
      check("m_valid", soc_if.irq_valid, m_pend != '0);
      check("m_id", soc_if.irq_id, low_id(m_pend));
      check("m_ack_err", soc_if.ack_err, m_err);
      check("m_eoi", eoi_o, eoi_vec());
`ifdef IRQ_OVF_TRACK_EN
      check("m_ovf", ovf_o, m_ovf);
`endif
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic ack(input int id);
    ack_v = 1'b1; ack_i = IDW'(id);
    tick(1);
    ack_v = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- directed stimulus
  initial begin
    int k;
    logic [N-1:0] snap_p, snap_e;
    pad_v = '0; en_v = '1; edge_v = '1; edge_v[7] = 1'b0;
    ack_v = 1'b0; ack_i = '0;
    sm_pad = '0; sm_en = '1; sm_edge = '1;
    sm_if.ack_valid = 1'b0; sm_if.ack_id = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_pending", soc_if.irq_pending, 0);
    check("rst_valid", soc_if.irq_valid, 0);
    check("rst_id", soc_if.irq_id, 0);
    check("rst_eoi", eoi_o, 0);
    check("rst_ack_err", soc_if.ack_err, 0);
    rst = 1'b0;
    cmp_on = 1'b1;
    tick(2);

    // step on channel 3: pending exactly 2+4+1 cycles later
    pad_v[3] = 1'b1;
    for (k = 1; k <= 20; k++) begin
      tick(1);
      if (soc_if.irq_pending[3]) break;
    end
    check("ch3_latency", k, 7);
    check("ch3_valid", soc_if.irq_valid, 1);
    check("ch3_id", soc_if.irq_id, 3);
    ack(3);
    check("ch3_acked", soc_if.irq_pending[3], 0);
    check("ch3_eoi_on", eoi_o[3], 1);

    // glitch filter on channel 0
    pad_v[0] = 1'b1; tick(3); pad_v[0] = 1'b0; tick(12);
    check("glitch3_dropped", soc_if.irq_pending[0], 0);
    pad_v[0] = 1'b1; tick(4); pad_v[0] = 1'b0; tick(12);
    check("pulse4_kept", soc_if.irq_pending[0], 1);
    ack(0);

    // channels 5 and 2, ack 2
    pad_v[5] = 1'b1; pad_v[2] = 1'b1; tick(10);
    check("ch25_pending", soc_if.irq_pending & 16'h0024, 16'h0024);
    check("ch25_id", soc_if.irq_id, 2);
    ack(2);
    check("ack2_cleared", soc_if.irq_pending[2], 0);
    check("ack2_id", soc_if.irq_id, 5);
    k = 0;
    while (eoi_o[2] && k < 30) begin k++; tick(1); end
    check("eoi2_width", k, 8);

    // level channel 7: masked for the EOI window, re-pends right after it
    pad_v[7] = 1'b1; tick(8);
    check("lvl7_pending", soc_if.irq_pending[7], 1);
    ack(7);
    check("lvl7_acked", soc_if.irq_pending[7], 0);
    k = 0;
    while (!soc_if.irq_pending[7] && k < 30) begin k++; tick(1); end
    check("lvl7_gap", k, EP + 1);
    pad_v[7] = 1'b0; tick(8);
    ack(7);
    tick(12);

    // invalid ack: channel 9 not pending
    snap_p = soc_if.irq_pending; snap_e = eoi_o;
    ack(9);
    check("ack9_err", soc_if.ack_err, 1);
    check("ack9_pending", soc_if.irq_pending, snap_p);
    check("ack9_eoi", eoi_o, snap_e);
    tick(1);
    check("ack9_err_pulse", soc_if.ack_err, 0);

    // ack during an active EOI pulse restarts it
    pad_v[9] = 1'b1; tick(10);
    pad_v[9] = 1'b0; tick(4); pad_v[9] = 1'b1; tick(1);
    ack(9);
    k = 0;
    while (!soc_if.irq_pending[9] && k < 20) begin k++; tick(1); end
    check("ch9_repend_in_eoi", eoi_o[9], 1);
    ack(9);
    k = 0;
    while (eoi_o[9] && k < 30) begin k++; tick(1); end
    check("eoi9_restart_width", k, 8);

    // enable masks set but never clears
    en_v[6] = 1'b0; pad_v[6] = 1'b1; tick(10);
    check("en6_masked", soc_if.irq_pending[6], 0);
    en_v[6] = 1'b1; tick(3);
    check("en6_no_late_set", soc_if.irq_pending[6], 0);
    en_v[5] = 1'b0; tick(2);
    check("en5_keeps", soc_if.irq_pending[5], 1);
    en_v[5] = 1'b1;

    // repeated edges on channel 1, then set and ack on the same edge
    pad_v[1] = 1'b1; tick(10); pad_v[1] = 1'b0; tick(10); pad_v[1] = 1'b1; tick(10);
`ifdef IRQ_OVF_TRACK_EN
    check("ovf1_set", ovf_o[1], 1);
`endif
    ack(1);
`ifdef IRQ_OVF_TRACK_EN
    check("ovf1_cleared", ovf_o[1], 0);
`endif
    pad_v[1] = 1'b0; tick(10); pad_v[1] = 1'b1; tick(10);
    pad_v[1] = 1'b0; tick(10); pad_v[1] = 1'b1; tick(6);
    ack(1);
    check("set_wins_pending", soc_if.irq_pending[1], 1);
    check("set_wins_eoi", eoi_o[1], 1);
`ifdef IRQ_OVF_TRACK_EN
    check("set_wins_ovf", ovf_o[1], 1);
`endif

    // reset in the middle of an EOI pulse
    ack(5);
    tick(2);
    check("pre_rst_eoi5", eoi_o[5], 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_eoi", eoi_o, 0);
    check("rst_mid_pending", soc_if.irq_pending, 0);
    check("rst_mid_valid", soc_if.irq_valid, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick(12);

    // out-of-range ack on the 5-channel instance
    sm_if.ack_valid = 1'b1; sm_if.ack_id = 3'd6;
    tick(1);
    sm_if.ack_valid = 1'b0;
    check("sm_oor_err", sm_if.ack_err, 1);
    check("sm_oor_pending", sm_if.irq_pending, 0);
    check("sm_oor_eoi", sm_eoi, 0);
    tick(1);
    check("sm_oor_err_pulse", sm_if.ack_err, 0);
    sm_if.ack_valid = 1'b1; sm_if.ack_id = 3'd4;
    tick(1);
    sm_if.ack_valid = 1'b0;
    check("sm_np_err", sm_if.ack_err, 1);
    tick(10);

    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
